gpio_bus_arbiter: RTL and testbench
===================================

# gpio_bus_arbiter

Round-robin arbiter that shares the single register port of one GPIO instance (write address, read address, byte-enable, write data, read data) between `REQ_NUM` bus requesters, e.g. the CPU bus bridge and a pin-scan sequencer. It accepts at most one access per cycle, drives the GPIO port from registers, and routes the read data back to the requester that issued the read. It sits between the requesters and the GPIO block's `addrIn`/`addrOut`/`sizeDecode`/`dataIn`/`dataOut` ports.

## Interface
- `REQ_NUM`, 2, number of requesters; legal range 2..4
- `clk`  in  1  system clock; all state changes on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `req`  in  REQ_NUM  per-requester access request
- `we`  in  REQ_NUM  per-requester access type: 1 = write, 0 = read
- `addr`  in  8*REQ_NUM  per-requester register address, packed with requester i at bits [8i+7:8i]
- `be`  in  4*REQ_NUM  per-requester byte enables for writes, packed
- `wdata`  in  32*REQ_NUM  per-requester write data, packed
- `gnt`  out  REQ_NUM  one-hot access accepted this cycle; combinational
- `rvalid`  out  REQ_NUM  one-hot read data valid for requester i
- `rdata`  out  32  read data, shared by all requesters; qualified by `rvalid`
- `addrIn`  out  8  GPIO write address
- `addrOut`  out  8  GPIO read address
- `sizeDecode`  out  4  GPIO byte-enable; nonzero only for writes
- `dataIn`  out  32  GPIO write data
- `dataOut`  in  32  GPIO read data; valid one cycle after `addrOut` is presented

## Operation
- Requester i holds `req[i]` and its `we`/`addr`/`be`/`wdata` stable until it sees `gnt[i]`. The accepted access completes in the same cycle that `gnt[i]` is high.
- Arbitration is round-robin with a `last` pointer. Priority order starts at `last+1` and wraps modulo `REQ_NUM`. On a grant, `last` takes the granted index.
- `gnt` is a pure function of `req` and `last`. It is all-zero when no request is pending, and never has more than one bit set.
- After reset, `last = REQ_NUM-1`, so requester 0 has highest priority.
- Stage 1 (port register, loaded on every edge):
  - Granted write: `addrIn=addr_i`, `dataIn=wdata_i`, `sizeDecode=be_i`, `addrOut=0`.
  - Granted read: `addrOut=addr_i`, `sizeDecode=0`, `addrIn=0`, `dataIn=0`.
  - No grant: all four port outputs return to 0.
- A write with `be=0` is still granted, but writes nothing.
- Stage 2 (response): a one-hot register captures the read requester from stage 1. `rvalid` equals that register, and `rdata=dataOut` combinationally. `rdata` is don't-care when `rvalid=0`.
- Reads and writes can be granted back-to-back every cycle. Any pipeline mix is legal because at most one transaction occupies each stage.

## Timing
- Reset values:
  - Register outputs: `addrIn`, `addrOut`, `dataIn`, `sizeDecode`, `rvalid` all 0.
  - `gnt` reflects `req` combinationally; it must be forced to 0 while `rst=1`.
- Write: granted at cycle T, GPIO port driven during T+1, GPIO register updated at the end of T+1.
- Read: granted at cycle T, `addrOut` driven during T+1, `rvalid`/`rdata` valid during T+2. Read latency is 2 cycles and fixed.
- Simultaneous requests: exactly one is granted per cycle. Under continuous contention each requester is granted at least once every `REQ_NUM` cycles.
- Reset mid-operation: accesses in stage 1 or stage 2 are dropped. No `rvalid` is produced for them, and the port returns to idle on the following cycle.
- `req` dropped before grant: this is legal. Nothing is issued and `last` is unchanged.

## Structure
- Shared package `gpio_pkg`:
  - GPIO address width (8), data width (32), byte-enable width (4)
  - idle port constants
  - read latency constant (2)
- One sub-module, `rr_arbiter`, is natural:
  - parameterised on `REQ_NUM`
  - inputs: `req`, advance strobe
  - outputs: one-hot `gnt`, plus the `last` register
- `gpio_bus_arbiter` instantiates `rr_arbiter` and adds the packed-field mux, stage-1 port registers, and stage-2 response register.

## Test plan
- Reset, then all `req=0` -> `gnt=0`, `rvalid=0`, and all port outputs 0 on every cycle.
- Requester 0 writes `addr=2`, `be=4'b1111`, `wdata=32'h00550055` -> `gnt[0]` at T; at T+1, `addrIn=2`, `dataIn=32'h00550055`, `sizeDecode=4'hF`; at T+2, `sizeDecode=0`.
- Requester 1 reads `addr=1`, with the GPIO model returning `32'hFFFFFFFF` -> `addrOut=1`, `sizeDecode=0` at T+1; `rvalid=2'b10`, `rdata=32'hFFFFFFFF` at T+2.
- With `REQ_NUM=2`, both `req` held high for 6 cycles -> grant sequence is 0,1,0,1,0,1, and a read issued by each requester returns `rvalid` to the correct requester 2 cycles after its own grant.
- Back-to-back: requester 0 writes then reads the same address in consecutive cycles -> the write is applied at T+1, the read is presented at T+2, and the read returns the new value at T+3.
- `rst` asserted the cycle after a read grant -> no `rvalid` ever appears for that read, all outputs are 0 the next cycle, and arbitration restarts with requester 0 highest priority.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO register port: field widths, the idle port value
// and the fixed read latency seen by bus requesters.
package gpio_pkg;

  localparam int GPIO_AW     = 8;
  localparam int GPIO_DW     = 32;
  localparam int GPIO_BEW    = 4;
  localparam int GPIO_RD_LAT = 2;

  typedef struct packed {
    logic [GPIO_AW-1:0]  addr_in;
    logic [GPIO_AW-1:0]  addr_out;
    logic [GPIO_BEW-1:0] size_decode;
    logic [GPIO_DW-1:0]  data_in;
  } gpio_port_t;

  localparam gpio_port_t PORT_IDLE = '0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant from req and the last-granted pointer.
// Grant is forced low during reset; last advances only when something is granted.
module rr_arbiter #(
  parameter int REQ_NUM = 2,
  parameter int LW      = $clog2(REQ_NUM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REQ_NUM-1:0] req,
  input  logic               adv,
  output logic [REQ_NUM-1:0] gnt,
  output logic [LW-1:0]      last
);

  logic [LW-1:0] last_q, last_d;
  logic [LW-1:0] idx;
  logic [LW-1:0] win_idx;
  logic          found;

  // Scan from last+1 upward, wrapping, and take the first requester seen.
  always_comb begin
    gnt     = '0;
    found   = 1'b0;
    idx     = '0;
    win_idx = last_q;
    for (int k = 1; k <= REQ_NUM; k++) begin
      idx = LW'((int'(last_q) + k) % REQ_NUM);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        win_idx  = idx;
        found    = 1'b1;
      end
    end
    if (rst) begin
      gnt = '0;
    end
  end

  always_comb begin
    last_d = last_q;
    if (adv && found && !rst) begin
      last_d = win_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= LW'(REQ_NUM - 1);
    end else begin
      last_q <= last_d;
    end
  end

  assign last = last_q;

endmodule

// File: rtl/gpio_bus_arbiter.sv
// Shares one GPIO register port between REQ_NUM requesters: round-robin grant,
// registered port drive (stage 1) and a read-return pipeline routing rvalid.
module gpio_bus_arbiter
  import gpio_pkg::*;
#(
  parameter int REQ_NUM = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [REQ_NUM-1:0]           req,
  input  logic [REQ_NUM-1:0]           we,
  input  logic [GPIO_AW*REQ_NUM-1:0]   addr,
  input  logic [GPIO_BEW*REQ_NUM-1:0]  be,
  input  logic [GPIO_DW*REQ_NUM-1:0]   wdata,
  output logic [REQ_NUM-1:0]           gnt,
  output logic [REQ_NUM-1:0]           rvalid,
  output logic [GPIO_DW-1:0]           rdata,
  output logic [GPIO_AW-1:0]           addrIn,
  output logic [GPIO_AW-1:0]           addrOut,
  output logic [GPIO_BEW-1:0]          sizeDecode,
  output logic [GPIO_DW-1:0]           dataIn,
  input  logic [GPIO_DW-1:0]           dataOut,
  output logic [$clog2(REQ_NUM)-1:0]   dbg_last
);

  // Handshake: a requester holds req[i] and its fields stable until gnt[i];
  // the access is accepted in the cycle gnt[i] is high, with no back-pressure after.

  gpio_port_t         port_q, port_d;
  logic [REQ_NUM-1:0] rd_pipe_q [GPIO_RD_LAT];

  rr_arbiter #(.REQ_NUM(REQ_NUM)) u_rr (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .adv  (|gnt),
    .gnt  (gnt),
    .last (dbg_last)
  );

  always_comb begin
    port_d = PORT_IDLE;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (gnt[i]) begin
        if (we[i]) begin
          port_d.addr_in     = addr[GPIO_AW*i +: GPIO_AW];
          port_d.data_in     = wdata[GPIO_DW*i +: GPIO_DW];
          port_d.size_decode = be[GPIO_BEW*i +: GPIO_BEW];
        end else begin
          port_d.addr_out    = addr[GPIO_AW*i +: GPIO_AW];
        end
      end
    end
  end

  // Read ownership travels alongside the access so the reply reaches its issuer.
  always_ff @(posedge clk) begin
    if (rst) begin
      port_q <= PORT_IDLE;
      for (int s = 0; s < GPIO_RD_LAT; s++) begin
        rd_pipe_q[s] <= '0;
      end
    end else begin
      port_q       <= port_d;
      rd_pipe_q[0] <= gnt & ~we;
      for (int s = 1; s < GPIO_RD_LAT; s++) begin
        rd_pipe_q[s] <= rd_pipe_q[s-1];
      end
    end
  end

  assign addrIn     = port_q.addr_in;
  assign addrOut    = port_q.addr_out;
  assign sizeDecode = port_q.size_decode;
  assign dataIn     = port_q.data_in;
  assign rvalid     = rd_pipe_q[GPIO_RD_LAT-1];
  assign rdata      = dataOut;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Directed bench for gpio_bus_arbiter with two requesters and a small GPIO
// register-file model that answers reads one cycle after addrOut.
module tb_gpio_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  we = '0;
  logic [15:0] addr = '0;
  logic [7:0]  be = '0;
  logic [63:0] wdata = '0;
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic [31:0] rdata;
  logic [7:0]  addrIn;
  logic [7:0]  addrOut;
  logic [3:0]  sizeDecode;
  logic [31:0] dataIn;
  logic [31:0] dataOut = '0;
  logic [0:0]  dbg_last;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mem [256];

  gpio_bus_arbiter #(.REQ_NUM(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .be         (be),
    .wdata      (wdata),
    .gnt        (gnt),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .addrIn     (addrIn),
    .addrOut    (addrOut),
    .sizeDecode (sizeDecode),
    .dataIn     (dataIn),
    .dataOut    (dataOut),
    .dbg_last   (dbg_last)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // GPIO model: read data registered from addrOut, byte-enabled write at the edge.
  always @(posedge clk) begin
    dataOut <= mem[addrOut];
    for (int b = 0; b < 4; b++) begin
      if (sizeDecode[b]) mem[addrIn][8*b +: 8] = dataIn[8*b +: 8];
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_port_idle(input string tag);
    chk({tag, "_addrIn"}, 32'(addrIn), 32'h0);
    chk({tag, "_addrOut"}, 32'(addrOut), 32'h0);
    chk({tag, "_size"}, 32'(sizeDecode), 32'h0);
    chk({tag, "_dataIn"}, dataIn, 32'h0);
  endtask

  initial begin
    logic [1:0] exp_g;
    logic [1:0] exp_rv;
    for (int a = 0; a < 256; a++) mem[a] = '0;
    mem[1] = 32'hFFFFFFFF;
    mem[3] = 32'h33333333;
    mem[4] = 32'h44444444;
    mem[5] = 32'h11111111;

    // reset: gnt forced low even with requests pending
    tick();
    req = 2'b11;
    settle();
    chk("rst_gnt", 32'(gnt), 32'h0);
    tick();
    chk_port_idle("rst");
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    req = 2'b00;
    rst = 1'b0;

    // idle cycles
    for (int c = 0; c < 3; c++) begin
      tick();
      settle();
      chk("idle_gnt", 32'(gnt), 32'h0);
      chk("idle_rvalid", 32'(rvalid), 32'h0);
      chk_port_idle("idle");
    end
    chk("idle_last", 32'(dbg_last), 32'h1);

    // requester 0 write
    tick();
    req = 2'b01; we = 2'b01; addr[7:0] = 8'd2; be[3:0] = 4'hF; wdata[31:0] = 32'h00550055;
    settle();
    chk("wr_gnt", 32'(gnt), 32'h1);
    tick();
    req = 2'b00;
    settle();
    chk("wr_addrIn", 32'(addrIn), 32'h2);
    chk("wr_dataIn", dataIn, 32'h00550055);
    chk("wr_size", 32'(sizeDecode), 32'hF);
    chk("wr_addrOut", 32'(addrOut), 32'h0);
    tick();
    settle();
    chk("wr_size_t2", 32'(sizeDecode), 32'h0);
    chk("wr_rvalid_t2", 32'(rvalid), 32'h0);
    chk("wr_last", 32'(dbg_last), 32'h0);

    // requester 1 read
    req = 2'b10; we = 2'b00; addr[15:8] = 8'd1;
    settle();
    chk("rd_gnt", 32'(gnt), 32'h2);
    tick();
    req = 2'b00;
    settle();
    chk("rd_addrOut", 32'(addrOut), 32'h1);
    chk("rd_size", 32'(sizeDecode), 32'h0);
    chk("rd_rvalid_t1", 32'(rvalid), 32'h0);
    tick();
    settle();
    chk("rd_rvalid", 32'(rvalid), 32'h2);
    chk("rd_rdata", rdata, 32'hFFFFFFFF);
    chk("rd_last", 32'(dbg_last), 32'h1);

    // contention: both reading, grants alternate 0,1,0,1,0,1
    addr[7:0] = 8'd3; addr[15:8] = 8'd4; we = 2'b00;
    for (int c = 0; c < 8; c++) begin
      tick();
      req = (c < 6) ? 2'b11 : 2'b00;
      settle();
      exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
      if (c < 6) chk("rr_gnt", 32'(gnt), 32'(exp_g));
      else       chk("rr_gnt_off", 32'(gnt), 32'h0);
      if (c >= 2) begin
        exp_rv = (c % 2 == 0) ? 2'b01 : 2'b10;
        chk("rr_rvalid", 32'(rvalid), 32'(exp_rv));
        chk("rr_rdata", rdata, (c % 2 == 0) ? 32'h33333333 : 32'h44444444);
      end
    end

    // back-to-back write then read of the same address by requester 0
    tick();
    req = 2'b01; we = 2'b01; addr[7:0] = 8'd5; be[3:0] = 4'b0011; wdata[31:0] = 32'hAABBCCDD;
    settle();
    chk("b2b_wr_gnt", 32'(gnt), 32'h1);
    tick();
    we = 2'b00;
    settle();
    chk("b2b_rd_gnt", 32'(gnt), 32'h1);
    chk("b2b_addrIn", 32'(addrIn), 32'h5);
    chk("b2b_size", 32'(sizeDecode), 32'h3);
    tick();
    req = 2'b00;
    settle();
    chk("b2b_addrOut", 32'(addrOut), 32'h5);
    chk("b2b_size_rd", 32'(sizeDecode), 32'h0);
    tick();
    settle();
    chk("b2b_rvalid", 32'(rvalid), 32'h1);
    chk("b2b_rdata", rdata, 32'h1111CCDD);

    // write with be=0 is granted but carries no byte enables
    req = 2'b10; we = 2'b10; addr[15:8] = 8'd5; be[7:4] = 4'h0; wdata[63:32] = 32'hDEADBEEF;
    settle();
    chk("be0_gnt", 32'(gnt), 32'h2);
    tick();
    req = 2'b00;
    settle();
    chk("be0_size", 32'(sizeDecode), 32'h0);
    chk("be0_addrIn", 32'(addrIn), 32'h5);
    tick();

    // prime last=0 so restart priority is observable, then read + reset
    req = 2'b01; we = 2'b00; addr[7:0] = 8'd1;
    settle();
    chk("rst_rd_gnt", 32'(gnt), 32'h1);
    tick();
    req = 2'b00; rst = 1'b1;
    settle();
    chk("rst_mid_gnt", 32'(gnt), 32'h0);
    tick();
    rst = 1'b0;
    req = 2'b11; we = 2'b11; be = 8'h00;
    settle();
    chk("rst_after_rvalid", 32'(rvalid), 32'h0);
    chk_port_idle("rst_after");
    chk("rst_after_last", 32'(dbg_last), 32'h1);
    chk("rst_after_gnt", 32'(gnt), 32'h1);
    tick();
    req = 2'b00;
    settle();
    chk("rst_after_rvalid2", 32'(rvalid), 32'h0);
    tick();
    settle();
    chk("rst_after_rvalid3", 32'(rvalid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
